// File: rtl/dac_ramp_envelope.sv
// Linear ramp-up / hold / ramp-down amplitude envelope applied to the composed DAC word.
// The factor is unsigned Q1.15 and the datapath is a fixed 3-stage registered multiply.
module dac_ramp_envelope #(
    parameter int UNITY = 32768
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic [15:0] signal_in,
    input  logic        signal_valid_in,
    input  logic [15:0] ramp_step,
    input  logic        start_up,
    input  logic        start_down,
    output logic [15:0] signal_out,
    output logic        signal_valid_out,
    output logic [1:0]  ramp_state,
    output logic [16:0] factor,
    output logic        up_done,
    output logic        down_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        HOLD = 2'd2,
        DOWN = 2'd3
    } ramp_state_t;

    localparam logic [16:0] UNITY_F = 17'(UNITY);

    ramp_state_t state_q, state_d;
    logic [16:0] factor_q, factor_d;
    logic        up_done_q, up_done_d;
    logic        down_done_q, down_done_d;

    logic        take_up;
    logic        take_down;
    logic [17:0] sum_up;

    // A request on the same edge as an update wins; start_down beats start_up.
    assign take_down = start_down && (state_q == UP || state_q == HOLD);
    assign take_up   = start_up && !start_down && (state_q == IDLE || state_q == DOWN);
    assign sum_up    = {1'b0, factor_q} + {2'b0, ramp_step};

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d     = state_q;
        factor_d    = factor_q;
        up_done_d   = 1'b0;
        down_done_d = 1'b0;
        if (take_down) begin
            state_d = DOWN;
        end else if (take_up) begin
            state_d = UP;
        end else if (signal_valid_in) begin
            case (state_q)
                UP: begin
                    if (ramp_step == 16'd0 || sum_up >= {1'b0, UNITY_F}) begin
                        factor_d  = UNITY_F;
                        state_d   = HOLD;
                        up_done_d = 1'b1;
                    end else begin
                        factor_d = sum_up[16:0];
                    end
                end
                DOWN: begin
                    if (ramp_step == 16'd0 || {1'b0, ramp_step} >= factor_q) begin
                        factor_d    = 17'd0;
                        state_d     = IDLE;
                        down_done_d = 1'b1;
                    end else begin
                        factor_d = factor_q - {1'b0, ramp_step};
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            factor_q    <= 17'd0;
            up_done_q   <= 1'b0;
            down_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            factor_q    <= factor_d;
            up_done_q   <= up_done_d;
            down_done_q <= down_done_d;
        end
    end

    logic signed [15:0] s1_data;
    logic        [16:0] s1_factor;
    logic               s1_valid;
    logic signed [32:0] s2_product;
    logic               s2_valid;
    logic signed [15:0] s3_data;
    logic               s3_valid;
    logic signed [32:0] product_c;

    // Factor is zero-extended so the multiply stays signed; |result| < 2^31 fits in 33 bits.
    assign product_c = $signed({{17{s1_data[15]}}, s1_data}) * $signed({16'b0, s1_factor});

    // NOTE: the pipeline has no memories, so every stage is cleared on reset to give a clean zero output.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            s1_data    <= '0;
            s1_factor  <= '0;
            s1_valid   <= 1'b0;
            s2_product <= '0;
            s2_valid   <= 1'b0;
            s3_data    <= '0;
            s3_valid   <= 1'b0;
        end else begin
            s1_data    <= signal_in;
            s1_factor  <= factor_q;
            s1_valid   <= signal_valid_in;
            s2_product <= product_c;
            s2_valid   <= s1_valid;
            s3_data    <= 16'(s2_product >>> 15);
            s3_valid   <= s2_valid;
        end
    end

    assign signal_out       = s3_data;
    assign signal_valid_out = s3_valid;
    assign ramp_state       = state_q;
    assign factor           = factor_q;
    assign up_done          = up_done_q;
    assign down_done        = down_done_q;

endmodule

// File: tb/tb_dac_ramp_envelope.sv
// Self-checking bench for dac_ramp_envelope: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural envelope model.
module tb_dac_ramp_envelope;

    localparam int S_IDLE = 0;
    localparam int S_UP   = 1;
    localparam int S_HOLD = 2;
    localparam int S_DOWN = 3;
    localparam int FULL   = 32768;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic [15:0] signal_in = '0;
    logic        signal_valid_in = 1'b0;
    logic [15:0] ramp_step = '0;
    logic        start_up = 1'b0;
    logic        start_down = 1'b0;
    logic [15:0] signal_out;
    logic        signal_valid_out;
    logic [1:0]  ramp_state;
    logic [16:0] factor;
    logic        up_done;
    logic        down_done;

    int checks = 0;
    int failures = 0;
    int up_cnt = 0;
    int dn_cnt = 0;
    int outs[$];

    int m_state = S_IDLE;
    int m_factor = 0;
    int m_up = 0;
    int m_dn = 0;
    int pv[3] = '{0, 0, 0};
    int pd[3] = '{0, 0, 0};

    dac_ramp_envelope #(.UNITY(32768)) dut (
        .clk(clk),
        .aresetn(aresetn),
        .signal_in(signal_in),
        .signal_valid_in(signal_valid_in),
        .ramp_step(ramp_step),
        .start_up(start_up),
        .start_down(start_down),
        .signal_out(signal_out),
        .signal_valid_out(signal_valid_out),
        .ramp_state(ramp_state),
        .factor(factor),
        .up_done(up_done),
        .down_done(down_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Sample times gain in Q1.15, rounded toward minus infinity.
    function automatic int scaled(input int s, input int f);
        longint p;
        longint q;
        p = longint'(s) * longint'(f);
        if (p >= 0) q = p / 32768;
        else        q = -((-p + 32767) / 32768);
        return int'(q);
    endfunction

    // Reference model and per-cycle comparison.
    always @(posedge clk) begin
        int s;
        int st;
        bit req_up;
        bit req_dn;
        if (!aresetn) begin
            m_state = S_IDLE;
            m_factor = 0;
            m_up = 0;
            m_dn = 0;
            pv = '{0, 0, 0};
            pd = '{0, 0, 0};
        end else begin
            s = int'($signed(signal_in));
            st = int'(ramp_step);
            pv[2] = pv[1]; pd[2] = pd[1];
            pv[1] = pv[0]; pd[1] = pd[0];
            pv[0] = int'(signal_valid_in);
            pd[0] = scaled(s, m_factor);
            m_up = 0;
            m_dn = 0;
            req_dn = start_down && (m_state == S_UP || m_state == S_HOLD);
            req_up = start_up && !start_down && (m_state == S_IDLE || m_state == S_DOWN);
            if (req_dn) m_state = S_DOWN;
            else if (req_up) m_state = S_UP;
            else if (signal_valid_in) begin
                if (m_state == S_UP) begin
                    m_factor = (st == 0) ? FULL : ((m_factor + st > FULL) ? FULL : m_factor + st);
                    if (m_factor == FULL) begin m_state = S_HOLD; m_up = 1; end
                end else if (m_state == S_DOWN) begin
                    m_factor = (st == 0) ? 0 : ((m_factor - st < 0) ? 0 : m_factor - st);
                    if (m_factor == 0) begin m_state = S_IDLE; m_dn = 1; end
                end
            end
        end
        #1;
        check("ramp_state", ramp_state, m_state);
        check("factor", factor, m_factor);
        check("up_done", up_done, m_up);
        check("down_done", down_done, m_dn);
        check("valid_out", signal_valid_out, pv[2]);
        if (pv[2] != 0 || !aresetn)
            check("signal_out", $signed(signal_out), (aresetn ? pd[2] : 0));
        if (signal_valid_out) outs.push_back(int'($signed(signal_out)));
        if (up_done) up_cnt++;
        if (down_done) dn_cnt++;
    end

    // Drive one cycle of inputs at a falling edge and wait for the next falling edge.
    task automatic tick(input logic su, input logic sd, input logic v, input int d);
        start_up = su;
        start_down = sd;
        signal_valid_in = v;
        signal_in = 16'(d);
        @(negedge clk);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        aresetn = 1'b1;
    endtask

    function automatic int find_val(input int v);
        for (int i = 0; i < outs.size(); i++)
            if (outs[i] == v) return i;
        return -1;
    endfunction

    initial begin
        int idx;
        @(negedge clk);
        do_reset();
        check("rst_state", ramp_state, 0);
        check("rst_factor", factor, 0);
        check("rst_valid_out", signal_valid_out, 0);
        check("rst_signal_out", signal_out, 0);

        // Ramp up 16000 at step 8192.
        ramp_step = 16'd8192;
        for (int i = 0; i < 4; i++) tick(0, 0, 1, 16000);
        outs.delete();
        up_cnt = 0;
        tick(1, 0, 1, 16000);
        for (int i = 0; i < 10; i++) tick(0, 0, 1, 16000);
        check("up_factor", factor, 32768);
        check("up_state", ramp_state, 2);
        check("up_done_count", up_cnt, 1);
        idx = -1;
        for (int i = 0; i < outs.size(); i++)
            if (idx < 0 && outs[i] != 0) idx = i;
        check("up_seq_found", (idx >= 0 && idx + 5 <= outs.size()), 1);
        if (idx >= 0 && idx + 5 <= outs.size()) begin
            check("up_seq0", outs[idx], 4000);
            check("up_seq1", outs[idx + 1], 8000);
            check("up_seq2", outs[idx + 2], 12000);
            check("up_seq3", outs[idx + 3], 16000);
            check("up_seq4", outs[idx + 4], 16000);
        end

        // Ramp down -16000 at step 16384.
        ramp_step = 16'd16384;
        outs.delete();
        dn_cnt = 0;
        tick(0, 1, 1, -16000);
        for (int i = 0; i < 8; i++) tick(0, 0, 1, -16000);
        check("down_factor", factor, 0);
        check("down_state", ramp_state, 0);
        check("down_done_count", dn_cnt, 1);
        idx = find_val(-8000);
        check("down_seq_found", (idx >= 1 && idx + 1 < outs.size()), 1);
        if (idx >= 1 && idx + 1 < outs.size()) begin
            check("down_seq_prev", outs[idx - 1], -16000);
            check("down_seq_next", outs[idx + 1], 0);
        end

        // Rounding at factor 16384, held by reversals so both samples see the same factor.
        do_reset();
        ramp_step = 16'd16384;
        tick(1, 0, 0, 0);
        tick(0, 0, 1, 0);
        check("round_factor", factor, 16384);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0);
        outs.delete();
        tick(0, 1, 1, -3);
        tick(1, 0, 1, 3);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0);
        check("round_count", outs.size(), 2);
        if (outs.size() == 2) begin
            check("round_neg", outs[0], -2);
            check("round_pos", outs[1], 1);
        end

        // Reversal at 12288 with simultaneous requests.
        do_reset();
        ramp_step = 16'd4096;
        tick(1, 0, 1, 1000);
        for (int i = 0; i < 3; i++) tick(0, 0, 1, 1000);
        check("rev_factor_up", factor, 12288);
        tick(1, 1, 1, 1000);
        check("rev_both_state", ramp_state, 3);
        check("rev_both_factor", factor, 12288);
        tick(0, 0, 1, 1000);
        check("rev_f1", factor, 8192);
        tick(0, 0, 1, 1000);
        check("rev_f2", factor, 4096);
        tick(0, 0, 1, 1000);
        check("rev_f3", factor, 0);
        check("rev_idle", ramp_state, 0);

        // Valid gaps during UP.
        do_reset();
        ramp_step = 16'd8192;
        tick(1, 0, 1, 100);
        for (int i = 0; i < 4; i++) tick(0, 0, (i % 2) == 0, 100);
        check("gap_factor_half", factor, 16384);
        for (int i = 0; i < 4; i++) tick(0, 0, (i % 2) == 0, 100);
        check("gap_factor_full", factor, 32768);

        // Instantaneous ramp, then reset mid-ramp.
        do_reset();
        ramp_step = 16'd0;
        tick(1, 0, 0, 0);
        check("step0_up_state", ramp_state, 1);
        tick(0, 0, 1, 500);
        check("step0_hold", ramp_state, 2);
        check("step0_factor", factor, 32768);
        ramp_step = 16'd4096;
        tick(0, 1, 1, 500);
        tick(0, 0, 1, 500);
        check("mid_factor", factor, 28672);
        up_cnt = 0;
        dn_cnt = 0;
        aresetn = 1'b0;
        tick(0, 0, 1, 500);
        check("mid_rst_state", ramp_state, 0);
        check("mid_rst_factor", factor, 0);
        check("mid_rst_done", up_cnt + dn_cnt, 0);
        aresetn = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            aresetn = ($urandom_range(0, 299) != 0);
            case ($urandom_range(0, 3))
                0: ramp_step = 16'd0;
                1: ramp_step = 16'($urandom_range(1, 64));
                2: ramp_step = 16'($urandom_range(1024, 12000));
                default: ramp_step = 16'($urandom);
            endcase
            tick($urandom_range(0, 11) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) != 0, int'($urandom_range(0, 65535)) - 32768);
        end
        aresetn = 1'b1;
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dac_ramp_envelope.md
Name: dac_ramp_envelope

Overview:
- Sits directly downstream of signal_composer, between the composed DAC word and the DAC output register.
- Applies a linear ramp-up / hold / ramp-down amplitude envelope to the composed signal, so drive fields start and stop without steps.
- Envelope factor is unsigned Q1.15 (32768 = unity). It advances once per valid input sample.
- Output is a pipelined, valid-qualified DAC word.

Parameters:
- UNITY, 32768, factor value meaning gain 1.0; the factor register is 17 bits wide.

Ports:
- clk  in  1  DAC-domain clock.
- aresetn  in  1  Synchronous active-low reset.
- signal_in  in  16  Signed composed sample from signal_composer.
- signal_valid_in  in  1  Qualifies signal_in.
- ramp_step  in  16  Unsigned factor increment/decrement per valid sample; 0 means instantaneous.
- start_up  in  1  Single-cycle request to ramp up.
- start_down  in  1  Single-cycle request to ramp down.
- signal_out  out  16  Signed enveloped sample.
- signal_valid_out  out  1  signal_valid_in delayed by 3 cycles.
- ramp_state  out  2  Current state: IDLE=0, UP=1, HOLD=2, DOWN=3.
- factor  out  17  Current envelope factor, 0..32768.
- up_done  out  1  One-cycle pulse on the UP->HOLD transition.
- down_done  out  1  One-cycle pulse on the DOWN->IDLE transition.

Behaviour:
- Reset (aresetn=0 at a clk edge): all pipeline registers 0, signal_out=0, signal_valid_out=0, ramp_state=IDLE, factor=0, up_done=0, down_done=0.
  - Reset mid-ramp returns immediately to IDLE with factor 0; no done pulse is issued.
- Requests are sampled every clk, independent of signal_valid_in. A request takes effect on that edge: the state changes, the factor does not.
  - start_up in IDLE or DOWN -> UP; the ramp continues from the current factor, no jump.
  - start_down in UP or HOLD -> DOWN.
  - start_up and start_down in the same cycle: start_down wins.
  - start_up in UP or HOLD and start_down in DOWN or IDLE are ignored.
- Factor update happens only on cycles with signal_valid_in=1 and no request taking effect:
  - UP: factor <= min(factor+ramp_step, 32768). If the result is 32768 -> HOLD and pulse up_done.
  - DOWN: factor <= max(factor-ramp_step, 0). If the result is 0 -> IDLE and pulse down_done.
  - ramp_step=0 in UP: factor <= 32768, go to HOLD, pulse up_done.
  - ramp_step=0 in DOWN: factor <= 0, go to IDLE, pulse down_done.
  - IDLE and HOLD: factor is unchanged.
  - signal_valid_in=0: factor and state are frozen unless a request takes effect.
- Sample/factor pairing: a valid sample is multiplied by the factor value before that cycle's update. The first sample after start_up from IDLE therefore uses factor 0.
- Datapath, 3-cycle fixed latency:
  - Stage 1 registers signal_in, the current factor and the valid bit.
  - Stage 2 forms the signed 16 x 17-bit product (33 bits).
  - Stage 3 takes product >>> 15 (arithmetic shift, floor rounding) and truncates to 16 bits.
  - No overflow is possible because factor <= 32768.
- Invalid input cycles still traverse the pipeline, with signal_valid_out=0 and signal_out unconstrained.
- ramp_state, factor, up_done and down_done are registered. They reflect the state after each clk edge and are not aligned with the data pipeline.
- In IDLE with factor 0, valid samples produce signal_out=0.

Test Plan:
- Reset, then constant signal_in=16000 with valid every cycle, ramp_step=8192, start_up pulse:
  - outputs 0, 4000, 8000, 12000, 16000, 16000…, appearing 3 cycles after each input;
  - factor steps 8192→32768; up_done pulses once; ramp_state reads 2.
- From HOLD with signal_in=-16000, ramp_step=16384, start_down:
  - outputs -16000, -8000, then 0 thereafter;
  - down_done pulses once; ramp_state reads 0.
- Rounding: signal_in=-3 and +3 at factor 16384 -> outputs -2 and 1.
- Reversal: ramp_step=4096, start_down after 3 UP updates (factor 12288):
  - factor counts 8192, 4096, 0;
  - start_up and start_down asserted in the same cycle -> DOWN.
- Valid gaps: toggle signal_valid_in every other cycle during UP.
  - factor advances only on valid cycles; signal_valid_out replicates the pattern delayed 3 cycles.
- ramp_step=0: start_up -> HOLD after 1 valid sample, factor=32768. Assert aresetn=0 mid-ramp -> next cycle IDLE, factor 0, no done pulses.
